prf_mp: RTL
===========

PRF_MP -- requirements
Module: prf_mp

Interface
REQ-001 Parameter DATA_W, default 32: width of each register entry.
REQ-002 Parameter DEPTH, default 64: number of physical registers; power of two, minimum 8.
REQ-003 Parameter NRD, default 4: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports.
REQ-005 Parameter ZERO_REG, default 1: when 1, physical register 0 reads as zero and ignores writes.
REQ-006 Derived constant AW = log2(DEPTH).
REQ-007 clk2x  in  1  clock at twice the core rate; every flop in the block uses it.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-010 rd_data  out  NRD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W].
REQ-011 wr_en  in  NWR  per-port write enable.
REQ-012 wr_addr  in  NWR*AW  write addresses.
REQ-013 wr_data  in  NWR*DATA_W  write data.
REQ-014 phase  out  1  current core-cycle half: 0 = write slot, 1 = read slot.
REQ-015 conflict  out  1  registered flag: two enabled write ports targeted the same address in the last write slot.

Function
REQ-016 A core cycle spans two clk2x cycles; phase toggles on every clk2x rising edge.
REQ-017 Upstream holds all inputs stable for a full core cycle; the block samples wr_* at the edge ending phase 0 and rd_addr at the edge ending phase 1.
REQ-018 At the edge ending phase 0, every enabled write port updates its addressed entry.
REQ-019 Same-address writes: the highest-indexed enabled port wins, and conflict is set to 1 for the following core cycle.
REQ-020 conflict is updated only at the edge ending phase 0.
REQ-021 At the edge ending phase 1, each rd_data port loads the entry at its rd_addr.
REQ-022 rd_data holds that value through the next two clk2x edges, i.e. one full core cycle.
REQ-023 Read latency: rd_addr presented in core cycle N appears on rd_data during core cycle N+1.
REQ-024 Bypass: a read in core cycle N returns the data written in core cycle N when the addresses match, never the stale entry.
REQ-025 If more than one write port matches a read address, the bypassed value follows the same priority as REQ-019.
REQ-026 With ZERO_REG=1, writes to address 0 are discarded and do not contribute to conflict.
REQ-027 With ZERO_REG=1, reads of address 0 return 0, including through the bypass path.
REQ-028 Any number of read ports may read the same address in the same cycle, with no penalty.
REQ-029 Out-of-range addresses cannot occur because DEPTH is a power of two; no error handling is required.

Reset
REQ-030 While rst is asserted: phase=0, conflict=0, rd_data=0, and every storage entry=0.
REQ-031 Reset takes effect immediately regardless of phase.
REQ-032 A write sampled in the same edge as rst assertion is lost.
REQ-033 After rst deasserts, the first clk2x edge ends phase 0, i.e. the first write slot.

Structure
REQ-034 Shared package prf_pkg holds the default DATA_W, DEPTH, NRD and NWR constants and the phase encoding (PH_WR=0, PH_RD=1).
REQ-035 The per-read-port bypass and priority mux is a sub-module prf_rd_port, instantiated NRD times.
REQ-036 The storage array is an inferred flop array; no vendor RAM primitive or clock-multiplier instance is used inside the block.

Verification
REQ-037 Reset release: write p5=0xDEADBEEF on port 0, read p5 on port 2 in the next core cycle -> rd_data[2]=0xDEADBEEF one core cycle later.
REQ-038 Bypass: in one core cycle, write p9=0x12345678 and read p9 on all four ports -> all four ports show 0x12345678 in core cycle N+1.
REQ-039 Conflict: port 0 writes p3=0x1, port 1 writes p3=0x2 in the same cycle -> conflict=1 for one core cycle, and a later read of p3 returns 0x2.
REQ-040 Zero register: write p0=0xFFFFFFFF with ZERO_REG=1 -> reads of p0 return 0 in both the bypass cycle and later cycles, and conflict stays 0.
REQ-041 Reset mid-operation: assert rst during phase 1 after writing p7=0xA5A5A5A5 -> rd_data=0 and phase=0 immediately, and a later read of p7 returns 0.
REQ-042 Parameter sweep: DEPTH=128, NRD=6, NWR=3, DATA_W=64, with random traffic checked against a reference model including bypass and priority -> zero mismatches over 10000 core cycles.

Source files
------------

// File: rtl/prf_pkg.sv
// prf_mp shared definitions: default geometry
// and the core-cycle phase encoding.
package prf_pkg;

    localparam int DATA_W_D = 32;
    localparam int DEPTH_D  = 64;
    localparam int NRD_D    = 4;
    localparam int NWR_D    = 2;

    typedef enum logic {
        PH_WR = 1'b0,
        PH_RD = 1'b1
    } phase_e;

endpackage

// File: rtl/prf_mp_if.sv
// prf_mp register-file bus: read/write ports plus
// phase and conflict status back to the core.
interface prf_mp_if
    import prf_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int NRD    = NRD_D,
    parameter int NWR    = NWR_D
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  phase;
    logic                  conflict;

    modport master (
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  rd_data,
        input  phase,
        input  conflict
    );

    modport slave (
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output rd_data,
        output phase,
        output conflict
    );

endinterface

// File: rtl/prf_rd_port.sv
// One read port: picks the stored entry or the
// highest-indexed matching write, zero-reg forced.
module prf_rd_port #(
    parameter int DATA_W   = 32,
    parameter int AW       = 6,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]         raddr,
    input  logic [DATA_W-1:0]     entry,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]     rdata
);

    // later ports override earlier ones, so the
    // highest-indexed matching write wins
    always_comb begin
        rdata = entry;
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && waddr[i*AW +: AW] == raddr)
                rdata = wdata[i*DATA_W +: DATA_W];
        end
        if (ZERO_REG != 0 && raddr == '0)
            rdata = '0;
    end

endmodule

// File: rtl/prf_mp.sv
// Double-pumped physical register file: writes in
// the first clk2x half, reads in the second.
module prf_mp
    import prf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_D,
    parameter int DEPTH    = DEPTH_D,
    parameter int NRD      = NRD_D,
    parameter int NWR      = NWR_D,
    parameter int ZERO_REG = 1
) (
    input logic   clk2x,
    input logic   rst,
    prf_mp_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    phase_e ph;
    phase_e ph_nxt;
    logic   wr_slot;
    logic   rd_slot;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [NWR-1:0]        wen_eff;
    logic                  conf_c;
    logic                  conf_q;
    logic [NWR-1:0]        wen_q;
    logic [NWR*AW-1:0]     waddr_q;
    logic [NWR*DATA_W-1:0] wdata_q;
    logic [NRD*DATA_W-1:0] rd_c;
    logic [NRD*DATA_W-1:0] rd_q;

    // phase state register
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) ph <= PH_WR;
        else     ph <= ph_nxt;
    end

    // phase simply alternates every clk2x edge
    always_comb begin
        ph_nxt = PH_WR;
        unique case (ph)
            PH_WR: ph_nxt = PH_RD;
            PH_RD: ph_nxt = PH_WR;
        endcase
    end

    // slot strobes decoded from the phase
    always_comb begin
        wr_slot = (ph == PH_WR);
        rd_slot = (ph == PH_RD);
    end

    // writes to the zero register are dropped early
    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wen_eff[i] = bus.wr_en[i] &&
                !(ZERO_REG != 0 &&
                  bus.wr_addr[i*AW +: AW] == '0);
        end
    end

    // any two surviving writes aimed at one entry
    always_comb begin
        conf_c = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wen_eff[i] && wen_eff[j] &&
                    bus.wr_addr[i*AW +: AW] ==
                    bus.wr_addr[j*AW +: AW])
                    conf_c = 1'b1;
            end
        end
    end

    // storage update and write record at write-slot end
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
            wen_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            conf_q  <= 1'b0;
        end else if (wr_slot) begin
            for (int i = 0; i < NWR; i++) begin
                if (wen_eff[i])
                    mem[bus.wr_addr[i*AW +: AW]] <=
                        bus.wr_data[i*DATA_W +: DATA_W];
            end
            wen_q   <= wen_eff;
            waddr_q <= bus.wr_addr;
            wdata_q <= bus.wr_data;
            conf_q  <= conf_c;
        end
    end

    // one bypass/priority mux per read port
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.rd_addr[r*AW +: AW];

        prf_rd_port #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .raddr (ra),
            .entry (mem[ra]),
            .wen   (wen_q),
            .waddr (waddr_q),
            .wdata (wdata_q),
            .rdata (rd_c[r*DATA_W +: DATA_W])
        );
    end

    // read data captured at read-slot end, held a core cycle
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst)          rd_q <= '0;
        else if (rd_slot) rd_q <= rd_c;
    end

    assign bus.rd_data  = rd_q;
    assign bus.phase    = ph;
    assign bus.conflict = conf_q;

endmodule
